shift_pipe: RTL

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe_pkg.sv | 23 ++
 rtl/shift_pipe_srl.sv | 13 +
 rtl/shift_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the shift pipeline: data width, op encoding and
// the bit-reversal helper used to build left shifts from the right shifter.
package shift_pkg;

  localparam int SHIFT_W = 32;

  typedef enum logic [1:0] {
    SHIFT_OP_SLL     = 2'd0,
    SHIFT_OP_SRL     = 2'd1,
    SHIFT_OP_SRA     = 2'd2,
    SHIFT_OP_ILLEGAL = 2'd3
  } shift_op_e;

  function automatic logic [SHIFT_W-1:0] bit_reverse(input logic [SHIFT_W-1:0] v);
    logic [SHIFT_W-1:0] r;
    r = {SHIFT_W{1'b0}};
    for (int i = 0; i < SHIFT_W; i++) begin
      r[i] = v[SHIFT_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_srl.sv
// Combinational zero-filling logical right shifter; the only shifter in the
// pipeline, with left and arithmetic shifts derived around it.
module shift_right_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [4:0]   shamt,
  output logic [N-1:0] y
);

  assign y = a >> shamt;

endmodule

// File: rtl/shift_pipe.sv
// Two-stage valid/ready shift pipeline: S1 holds the accepted request,
// S2 holds the computed result presented on the output.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int N = SHIFT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [4:0]   in_shamt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         err,
  output logic [15:0]  done_count
);

  logic         s1_valid_r;
  logic [N-1:0] s1_data_r;
  logic [4:0]   s1_shamt_r;
  shift_op_e    s1_op_r;
  logic         s2_valid_r;
  logic [N-1:0] s2_data_r;
  logic         err_r;
  logic [15:0]  done_count_r;

  logic         accept_s;
  logic         s1_advance_s;
  logic         s2_drain_s;
  logic [N-1:0] srl_in_s;
  logic [N-1:0] srl_out_s;
  logic [N-1:0] shift_res_s;

  assign s2_drain_s   = s2_valid_r & out_ready;
  assign s1_advance_s = s1_valid_r & (~s2_valid_r | s2_drain_s);
  assign in_ready     = ~s1_valid_r | s1_advance_s;
  assign accept_s     = in_valid & in_ready;

  shift_right_logical #(.N(N)) u_srl (
    .a     (srl_in_s),
    .shamt (s1_shamt_r),
    .y     (srl_out_s)
  );

  // Operand conditioning and result recovery around the shared right shifter.
  // SRA of a negative value is ~(~x >> s), which fills the vacated bits with ones.
  always_comb begin
    srl_in_s    = s1_data_r;
    shift_res_s = {N{1'b0}};
    case (s1_op_r)
      SHIFT_OP_SLL: begin
        srl_in_s    = bit_reverse(s1_data_r);
        shift_res_s = bit_reverse(srl_out_s);
      end
      SHIFT_OP_SRL: begin
        shift_res_s = srl_out_s;
      end
      SHIFT_OP_SRA: begin
        if (s1_data_r[N-1]) begin
          srl_in_s    = ~s1_data_r;
          shift_res_s = ~srl_out_s;
        end else begin
          shift_res_s = srl_out_s;
        end
      end
      SHIFT_OP_ILLEGAL: begin
        shift_res_s = {N{1'b0}};
      end
      default: begin
        shift_res_s = {N{1'b0}};
      end
    endcase
  end

  // S1: capture accepted request; empties when it moves on with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {N{1'b0}};
      s1_shamt_r <= 5'd0;
      s1_op_r    <= SHIFT_OP_SLL;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= in_data;
      s1_shamt_r <= in_shamt;
      s1_op_r    <= shift_op_e'(in_op);
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2: register the result; held unchanged while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {N{1'b0}};
    end else if (s1_advance_s) begin
      s2_valid_r <= 1'b1;
      s2_data_r  <= shift_res_s;
    end else if (s2_drain_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Status: sticky illegal-op flag and wrapping count of consumed results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r        <= 1'b0;
      done_count_r <= 16'd0;
    end else begin
      if (accept_s && (in_op == 2'd3)) begin
        err_r <= 1'b1;
      end
      if (s2_drain_s) begin
        done_count_r <= done_count_r + 16'd1;
      end
    end
  end

  assign out_valid  = s2_valid_r;
  assign out_data   = s2_data_r;
  assign err        = err_r;
  assign done_count = done_count_r;

endmodule
